// File: rtl/powerup_timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : powerup_timer_bank
// Brief    : Bank of NUM_CH independent power-up countdown timers with a
//            shared seconds prescaler rate, global pause and clear.
//            Build option PP_STACK_EN: a re-eat while active adds time
//            instead of restarting the channel.
// Revision : 1.0 - initial release
// ============================================================================
module powerup_timer_bank #(
    parameter int NUM_CH    = 4,
    parameter int SEL_W     = 2,
    parameter int CNT_W     = 4,
    parameter int PRESCALER = 64999999,
    parameter int PRESC_W   = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    eaten,
    input  logic [SEL_W-1:0]        mode,
    input  logic [NUM_CH*CNT_W-1:0] duration,
    input  logic                    pause,
    input  logic                    clear_all,
    output logic [NUM_CH-1:0]       pp_status,
    output logic [NUM_CH*CNT_W-1:0] remaining,
    output logic [NUM_CH-1:0]       expire_pulse,
    output logic                    any_active
);

    localparam logic [0:0]         c_st_idle   = 1'b0;
    localparam logic [0:0]         c_st_active = 1'b1;
    localparam logic [PRESC_W-1:0] c_presc_max = PRESC_W'(PRESCALER);
    localparam logic [CNT_W-1:0]   c_cnt_max   = '1;

    logic [0:0]         r_state     [NUM_CH];
    logic [0:0]         w_state_nxt [NUM_CH];
    logic [PRESC_W-1:0] r_presc     [NUM_CH];
    logic [PRESC_W-1:0] w_presc_nxt [NUM_CH];
    logic [CNT_W-1:0]   r_rem       [NUM_CH];
    logic [CNT_W-1:0]   w_rem_nxt   [NUM_CH];
    logic               r_exp       [NUM_CH];
    logic               w_exp_nxt   [NUM_CH];

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= c_st_idle;
                r_presc[i] <= '0;
                r_rem[i]   <= '0;
                r_exp[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_presc[i] <= w_presc_nxt[i];
                r_rem[i]   <= w_rem_nxt[i];
                r_exp[i]   <= w_exp_nxt[i];
            end
        end
    end

    // Next-state logic: clear_all > load > countdown
    always_comb begin
        logic [CNT_W-1:0] w_dur;
        logic             w_load;
        logic             w_run;
        logic             w_tick;
`ifdef PP_STACK_EN
        logic [CNT_W:0]   w_sum;
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            w_dur  = duration[i*CNT_W +: CNT_W];
            w_load = eaten && (mode == SEL_W'(i)) && (w_dur != '0);
            w_run  = (r_state[i] == c_st_active) && !pause;
            w_tick = w_run && (r_presc[i] == c_presc_max);
`ifdef PP_STACK_EN
            w_sum  = '0;
`endif
            w_state_nxt[i] = r_state[i];
            w_presc_nxt[i] = r_presc[i];
            w_rem_nxt[i]   = r_rem[i];
            w_exp_nxt[i]   = 1'b0;

            if (clear_all) begin
                w_state_nxt[i] = c_st_idle;
                w_presc_nxt[i] = '0;
                w_rem_nxt[i]   = '0;
            end else if (w_load) begin
`ifdef PP_STACK_EN
                if (r_state[i] == c_st_active) begin
                    // Stacking keeps the prescaler phase; a coincident tick still consumes a second
                    w_sum = {1'b0, r_rem[i]} + {1'b0, w_dur} - {{CNT_W{1'b0}}, w_tick};
                    w_rem_nxt[i] = (w_sum > {1'b0, c_cnt_max}) ? c_cnt_max : w_sum[CNT_W-1:0];
                    if (w_tick)
                        w_presc_nxt[i] = '0;
                    else if (w_run)
                        w_presc_nxt[i] = r_presc[i] + PRESC_W'(1);
                end else begin
                    w_state_nxt[i] = c_st_active;
                    w_presc_nxt[i] = '0;
                    w_rem_nxt[i]   = w_dur;
                end
`else
                w_state_nxt[i] = c_st_active;
                w_presc_nxt[i] = '0;
                w_rem_nxt[i]   = w_dur;
`endif
            end else if (w_tick) begin
                w_presc_nxt[i] = '0;
                if (r_rem[i] == CNT_W'(1)) begin
                    w_state_nxt[i] = c_st_idle;
                    w_rem_nxt[i]   = '0;
                    w_exp_nxt[i]   = 1'b1;
                end else begin
                    w_rem_nxt[i]   = r_rem[i] - CNT_W'(1);
                end
            end else if (w_run) begin
                w_presc_nxt[i] = r_presc[i] + PRESC_W'(1);
            end
        end
    end

    // Outputs: direct views of the registered per-channel state
    always_comb begin
        pp_status    = '0;
        remaining    = '0;
        expire_pulse = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pp_status[i]                   = (r_state[i] == c_st_active);
            remaining[i*CNT_W +: CNT_W]    = r_rem[i];
            expire_pulse[i]                = r_exp[i];
        end
    end

    assign any_active = |pp_status;

endmodule
`default_nettype wire

// File: tb/tb_powerup_timer_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_powerup_timer_bank
// Brief    : Directed self-checking bench for powerup_timer_bank (PRESCALER=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_powerup_timer_bank;

    localparam int NUM_CH    = 4;
    localparam int SEL_W     = 2;
    localparam int CNT_W     = 4;
    localparam int PRESCALER = 3;
    localparam int PRESC_W   = 2;
`ifdef PP_STACK_EN
    localparam bit STACK = 1'b1;
`else
    localparam bit STACK = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    eaten;
    logic [SEL_W-1:0]        mode;
    logic [NUM_CH*CNT_W-1:0] duration;
    logic                    pause;
    logic                    clear_all;
    logic [NUM_CH-1:0]       pp_status;
    logic [NUM_CH*CNT_W-1:0] remaining;
    logic [NUM_CH-1:0]       expire_pulse;
    logic                    any_active;

    logic [2:0]              pp_status3;
    logic [3*CNT_W-1:0]      remaining3;
    logic [2:0]              expire_pulse3;
    logic                    any_active3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    powerup_timer_bank #(
        .NUM_CH(NUM_CH), .SEL_W(SEL_W), .CNT_W(CNT_W),
        .PRESCALER(PRESCALER), .PRESC_W(PRESC_W)
    ) u_dut (
        .clk(clk), .reset(reset), .eaten(eaten), .mode(mode),
        .duration(duration), .pause(pause), .clear_all(clear_all),
        .pp_status(pp_status), .remaining(remaining),
        .expire_pulse(expire_pulse), .any_active(any_active)
    );

    // Three-channel instance: mode==3 selects no channel
    powerup_timer_bank #(
        .NUM_CH(3), .SEL_W(SEL_W), .CNT_W(CNT_W),
        .PRESCALER(PRESCALER), .PRESC_W(PRESC_W)
    ) u_dut3 (
        .clk(clk), .reset(reset), .eaten(eaten), .mode(mode),
        .duration(duration[3*CNT_W-1:0]), .pause(pause), .clear_all(clear_all),
        .pp_status(pp_status3), .remaining(remaining3),
        .expire_pulse(expire_pulse3), .any_active(any_active3)
    );

    function automatic logic [CNT_W-1:0] rem_of(input int ch);
        return remaining[ch*CNT_W +: CNT_W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int ch, input int d);
        duration[ch*CNT_W +: CNT_W] = CNT_W'(d);
        mode  = SEL_W'(ch);
        eaten = 1'b1;
        step();
        eaten = 1'b0;
    endtask

    task automatic do_clear();
        clear_all = 1'b1;
        step();
        clear_all = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; eaten = 1'b1; mode = '0; duration = {NUM_CH{4'd3}};
        pause = 1'b0; clear_all = 1'b0;
        step(); step();
        checks++;
        if (pp_status !== '0 || remaining !== '0 || expire_pulse !== '0 || any_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pp=%b rem=%h exp=%b any=%b, required all 0",
                     pp_status, remaining, expire_pulse, any_active);
        end
        eaten = 1'b0; reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [CNT_W-1:0] exp_rem;
        load(0, 3);
        duration[CNT_W-1:0] = 4'd9;  // must not affect the running channel
        for (int c = 1; c <= 12; c++) begin
            exp_rem = CNT_W'(3 - (c - 1) / 4);
            checks++;
            if (pp_status[0] !== 1'b1 || rem_of(0) !== exp_rem || expire_pulse[0] !== 1'b0
                || any_active !== 1'b1) begin
                errors++;
                $display("FAIL basic_run c=%0d: pp=%b rem=%0d exp=%b any=%b, required 1 %0d 0 1",
                         c, pp_status[0], rem_of(0), expire_pulse[0], any_active, exp_rem);
            end
            step();
        end
        checks++;
        if (pp_status[0] !== 1'b0 || expire_pulse[0] !== 1'b1 || rem_of(0) !== '0) begin
            errors++;
            $display("FAIL basic_expire: pp=%b exp=%b rem=%0d, required 0 1 0",
                     pp_status[0], expire_pulse[0], rem_of(0));
        end
        step();
        checks++;
        if (expire_pulse !== '0 || any_active !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_width: exp=%b any=%b, required 0 0", expire_pulse, any_active);
        end
    endtask

    task automatic test_restart();
        int last;
        last = STACK ? 16 : 13;
        load(1, 2);
        for (int c = 1; c <= last; c++) begin
            checks++;
            if (pp_status[1] !== 1'b1 || expire_pulse[1] !== 1'b0) begin
                errors++;
                $display("FAIL restart_run c=%0d: pp=%b exp=%b, required 1 0",
                         c, pp_status[1], expire_pulse[1]);
            end
            if (c == 5) begin
                mode = 2'd1; eaten = 1'b1;
            end
            step();
            eaten = 1'b0;
        end
        checks++;
        if (pp_status[1] !== 1'b0 || expire_pulse[1] !== 1'b1) begin
            errors++;
            $display("FAIL restart_expire: pp=%b exp=%b, required 0 1", pp_status[1], expire_pulse[1]);
        end
        step();
    endtask

    task automatic test_stack();
        logic [CNT_W-1:0] exp_rem;
        load(2, 5);
        for (int c = 1; c < 9; c++) step();
        checks++;
        if (rem_of(2) !== 4'd3) begin
            errors++;
            $display("FAIL stack_pre: rem=%0d, required 3", rem_of(2));
        end
        load(2, 5);
        exp_rem = STACK ? 4'd8 : 4'd5;
        checks++;
        if (rem_of(2) !== exp_rem || pp_status[2] !== 1'b1) begin
            errors++;
            $display("FAIL stack_add: rem=%0d pp=%b, required %0d 1", rem_of(2), pp_status[2], exp_rem);
        end
        do_clear();
        load(2, 10);
        load(2, 10);
        exp_rem = STACK ? 4'd15 : 4'd10;
        checks++;
        if (rem_of(2) !== exp_rem || pp_status[2] !== 1'b1) begin
            errors++;
            $display("FAIL stack_saturate: rem=%0d pp=%b, required %0d 1", rem_of(2), pp_status[2], exp_rem);
        end
        do_clear();
    endtask

    task automatic test_pause();
        logic [CNT_W-1:0] exp_rem;
        load(0, 2);
        for (int c = 1; c <= 14; c++) begin
            if (c == 3) pause = 1'b1;
            if (c == 9) pause = 1'b0;
            exp_rem = (c <= 10) ? 4'd2 : 4'd1;
            checks++;
            if (pp_status[0] !== 1'b1 || rem_of(0) !== exp_rem || expire_pulse[0] !== 1'b0) begin
                errors++;
                $display("FAIL pause_run c=%0d: pp=%b rem=%0d exp=%b, required 1 %0d 0",
                         c, pp_status[0], rem_of(0), expire_pulse[0], exp_rem);
            end
            step();
        end
        checks++;
        if (pp_status[0] !== 1'b0 || expire_pulse[0] !== 1'b1) begin
            errors++;
            $display("FAIL pause_expire: pp=%b exp=%b, required 0 1", pp_status[0], expire_pulse[0]);
        end
        step();
    endtask

    task automatic test_clear();
        load(0, 4);
        load(3, 4);
        step(); step();
        clear_all = 1'b1; eaten = 1'b1; mode = 2'd3;
        step();
        clear_all = 1'b0; eaten = 1'b0;
        checks++;
        if (pp_status !== '0 || remaining !== '0 || expire_pulse !== '0 || any_active !== 1'b0) begin
            errors++;
            $display("FAIL clear_all: pp=%b rem=%h exp=%b any=%b, required all 0",
                     pp_status, remaining, expire_pulse, any_active);
        end
        step();
        checks++;
        if (pp_status !== '0 || expire_pulse !== '0) begin
            errors++;
            $display("FAIL clear_after: pp=%b exp=%b, required 0 0", pp_status, expire_pulse);
        end
    endtask

    task automatic test_reset_mid();
        load(1, 3);
        for (int c = 0; c < 5; c++) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if (pp_status !== '0 || remaining !== '0 || expire_pulse !== '0 || any_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: pp=%b rem=%h exp=%b any=%b, required all 0",
                     pp_status, remaining, expire_pulse, any_active);
        end
    endtask

    task automatic test_ignored();
        duration[3*CNT_W +: CNT_W] = 4'd5;
        mode = 2'd3; eaten = 1'b1;
        step();
        eaten = 1'b0;
        checks++;
        if (pp_status3 !== 3'b000 || remaining3 !== '0 || any_active3 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_mode: pp3=%b rem3=%h any3=%b, required 0 0 0",
                     pp_status3, remaining3, any_active3);
        end
        do_clear();
        load(0, 0);
        checks++;
        if (pp_status !== '0 || any_active !== 1'b0) begin
            errors++;
            $display("FAIL ignore_zero_idle: pp=%b any=%b, required 0 0", pp_status, any_active);
        end
        load(0, 2);
        load(0, 0);
        checks++;
        if (pp_status[0] !== 1'b1 || rem_of(0) !== 4'd2) begin
            errors++;
            $display("FAIL ignore_zero_active: pp=%b rem=%0d, required 1 2", pp_status[0], rem_of(0));
        end
        do_clear();
    endtask

    task automatic test_back_to_back();
        load(0, 1);
        step(); step(); step();
        checks++;
        if (pp_status[0] !== 1'b1 || rem_of(0) !== 4'd1) begin
            errors++;
            $display("FAIL final_tick_pre: pp=%b rem=%0d, required 1 1", pp_status[0], rem_of(0));
        end
        load(0, 2);
        checks++;
        if (pp_status[0] !== 1'b1 || rem_of(0) !== 4'd2 || expire_pulse[0] !== 1'b0) begin
            errors++;
            $display("FAIL final_tick_load: pp=%b rem=%0d exp=%b, required 1 2 0",
                     pp_status[0], rem_of(0), expire_pulse[0]);
        end
        do_clear();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_restart();
        test_stack();
        test_pause();
        test_clear();
        test_reset_mid();
        test_ignored();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/powerup_timer_bank.md
Name: powerup_timer_bank

Overview:
- Parametrised bank of NUM_CH independent power-up countdown timers for the Pong game.
- A power-up "eaten" event plus a channel select starts or re-arms one channel with a runtime-programmable duration in seconds.
- Per channel the block outputs active status, remaining seconds and a one-cycle expiry pulse.
- Sits between the power-up collision logic and the paddle/ball modifier logic. Adds global pause, clear and re-eat handling.

Parameters:
- NUM_CH, 4, number of timer channels (1..2**SEL_W).
- SEL_W, 2, width of channel select.
- CNT_W, 4, width of per-channel seconds counter; max duration 2**CNT_W-1.
- PRESCALER, 64999999, clk cycles per second minus one.
- PRESC_W, 26, prescaler counter width; must hold PRESCALER.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- eaten  in  1  single-cycle power-up event
- mode  in  SEL_W  channel selected by eaten
- duration  in  NUM_CH*CNT_W  per-channel load value in seconds; channel i at [i*CNT_W +: CNT_W]
- pause  in  1  freeze all countdowns while high
- clear_all  in  1  force all channels idle
- pp_status  out  NUM_CH  bit i high while channel i active
- remaining  out  NUM_CH*CNT_W  per-channel seconds left, same packing as duration
- expire_pulse  out  NUM_CH  one-cycle pulse when channel i times out naturally
- any_active  out  1  OR of pp_status

Behaviour:
- All outputs registered except any_active, which is the combinational OR of pp_status.
- Reset (reset==0 at clk edge): highest priority. All channels IDLE; pp_status=0, remaining=0, expire_pulse=0, prescalers=0. Applies mid-countdown.
- Per channel i: 2-state FSM, IDLE/ACTIVE, plus PRESC_W prescaler and CNT_W remaining counter.
- Priority per channel each cycle: reset > clear_all > load event > countdown.
- Load event: eaten==1, mode==i, duration slice D!=0.
  - mode>=NUM_CH or D==0: event ignored, no state change.
- Load from IDLE:
  - remaining<=D, prescaler<=0, state<=ACTIVE.
  - pp_status[i] high from the cycle after the eaten edge.
- Load while ACTIVE: see Optional Feature.
- Countdown (ACTIVE, pause==0):
  - prescaler increments each cycle.
  - At prescaler==PRESCALER: prescaler<=0 and remaining<=remaining-1.
  - If remaining==1 at that tick: state<=IDLE, remaining<=0, expire_pulse[i]<=1 for exactly one cycle.
  - pp_status high for exactly D*(PRESCALER+1) cycles with no pause or reload.
- pause==1: prescalers and remaining hold. Load events are still accepted. expire_pulse cannot fire.
- clear_all==1: every channel goes IDLE, remaining=0, prescaler=0, no expire_pulse. A same-cycle eaten is discarded.
- Load and final tick in the same cycle on the same channel: load wins; channel stays ACTIVE, no expire_pulse.
- expire_pulse is only asserted on natural timeout, never on clear or reset.
- Channels are fully independent; only one channel can load per cycle.
- Duration is sampled only on the load edge; later changes to duration do not affect a running channel.

Optional Feature:
- Macro: PP_STACK_EN.
- Defined: a load while ACTIVE adds time.
  - remaining<=min(remaining+D, 2**CNT_W-1); prescaler is not reset.
  - If a tick coincides with the load: remaining<=min(remaining-1+D, 2**CNT_W-1).
- Undefined: a load while ACTIVE restarts the channel: remaining<=D, prescaler<=0.

Test Plan:
- Basic countdown (PRESCALER=3, duration ch0=3, eaten mode=0 at cycle 0) -> pp_status[0] high cycles 1..12; remaining 3,2,1 each for 4 cycles; expire_pulse[0] high at cycle 13 only, when pp_status[0] falls.
- Restart without PP_STACK_EN (ch1 D=2, re-eat at cycle 5) -> pp_status[1] high cycles 1..13; no expire_pulse before cycle 14.
- With PP_STACK_EN (ch2 D=5, re-eat when remaining=3) -> remaining=8. Second scenario: D=10 eaten twice back-to-back -> remaining saturates at 15.
- Pause: ch0 D=2, pause high for 6 cycles starting at cycle 3 -> remaining frozen; pp_status[0] high 14 cycles total; expire_pulse delayed by 6 cycles.
- clear_all asserted with eaten same cycle while ch3 active -> all pp_status=0 next cycle, no expire_pulse. Reset driven low mid-count -> all outputs 0 next cycle.
- Ignored events (NUM_CH=3: mode=3 eaten; D=0 eaten on ch0) -> no state change. Load on ch0 coinciding with its final tick -> remains active, no expire_pulse.
